// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM model, with independent read/write FSMs.
// Define AXI_SLAVE_BURST_EN to honour awlen/arlen; otherwise every transaction is single-beat.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          MEM_WORDS  = 4096,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off} < MEM_BYTES;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  logic [1:0]  wstate;
  logic [31:0] waddr_q;
  logic [3:0]  wid_q;
  logic [7:0]  wlen_q, wbeat_q;
  logic        werr_q;
  logic        w_fire;

  logic [1:0]  rstate;
  logic [31:0] raddr_q;
  logic [3:0]  rid_q;
  logic [7:0]  rlen_q, rbeat_q;
  logic [3:0]  rcnt_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_addr;
  logic        rd_ok;
  logic [31:0] rd_val;

  logic unused_sink;
  assign unused_sink = ^{io_slave_awsize, io_slave_awburst, io_slave_arsize, io_slave_arburst,
                         io_slave_wlast, io_slave_awlen, io_slave_arlen};

  assign w_fire = !reset && (wstate == W_DATA) && io_slave_wvalid;

  // Write channel: address latch, data beats, single response
  always_ff @(posedge clock) begin
    if (reset) begin
      wstate <= W_IDLE;
    end else begin
      case (wstate)
        W_IDLE:  if (io_slave_awvalid) wstate <= W_DATA;
        W_DATA:  if (io_slave_wvalid && (wbeat_q == wlen_q)) wstate <= W_RESP;
        W_RESP:  if (io_slave_bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wstate == W_IDLE && io_slave_awvalid) begin
      waddr_q <= io_slave_awaddr;
      wid_q   <= io_slave_awid;
`ifdef AXI_SLAVE_BURST_EN
      wlen_q  <= io_slave_awlen;
`else
      wlen_q  <= 8'd0;
`endif
      wbeat_q <= 8'd0;
      werr_q  <= 1'b0;
    end else if (w_fire) begin
      waddr_q <= waddr_q + 32'd4;
      wbeat_q <= wbeat_q + 8'd1;
      werr_q  <= werr_q | !in_range(waddr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (w_fire && in_range(waddr_q)) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
    end
  end

  // Read channel: a beat advance fetches the following word on the same edge
  assign rd_addr = (rstate == R_DATA) ? raddr_q + 32'd4 : raddr_q;
  assign rd_ok   = in_range(rd_addr);
  assign rd_val  = rd_ok ? mem[word_idx(rd_addr)] : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      rstate <= R_IDLE;
    end else begin
      case (rstate)
        R_IDLE:  if (io_slave_arvalid) rstate <= R_WAIT;
        R_WAIT:  if (rcnt_q == 4'd0) rstate <= R_DATA;
        R_DATA:  if (io_slave_rready && (rbeat_q == rlen_q)) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    case (rstate)
      R_IDLE: begin
        if (io_slave_arvalid) begin
          raddr_q <= io_slave_araddr;
          rid_q   <= io_slave_arid;
`ifdef AXI_SLAVE_BURST_EN
          rlen_q  <= io_slave_arlen;
`else
          rlen_q  <= 8'd0;
`endif
          rbeat_q <= 8'd0;
          rcnt_q  <= 4'(RD_LATENCY);
        end
      end
      R_WAIT: begin
        if (rcnt_q == 4'd0) begin
          rdata_q <= rd_val;
          rresp_q <= rd_ok ? 2'b00 : 2'b10;
        end else begin
          rcnt_q <= rcnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (io_slave_rready && (rbeat_q != rlen_q)) begin
          raddr_q <= rd_addr;
          rbeat_q <= rbeat_q + 8'd1;
          rdata_q <= rd_val;
          rresp_q <= rd_ok ? 2'b00 : 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is high
  assign io_slave_awready = !reset && (wstate == W_IDLE);
  assign io_slave_wready  = !reset && (wstate == W_DATA);
  assign io_slave_bvalid  = !reset && (wstate == W_RESP);
  assign io_slave_bresp   = (io_slave_bvalid && werr_q) ? 2'b10 : 2'b00;
  assign io_slave_bid     = io_slave_bvalid ? wid_q : 4'd0;

  assign io_slave_arready = !reset && (rstate == R_IDLE);
  assign io_slave_rvalid  = !reset && (rstate == R_DATA);
  assign io_slave_rdata   = io_slave_rvalid ? rdata_q : 32'd0;
  assign io_slave_rresp   = io_slave_rvalid ? rresp_q : 2'b00;
  assign io_slave_rlast   = io_slave_rvalid && (rbeat_q == rlen_q);
  assign io_slave_rid     = io_slave_rvalid ? rid_q : 4'd0;
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (default geometry, RD_LATENCY=2).
// Burst steps are included when AXI_SLAVE_BURST_EN is defined.
module tb_axi_sram_slave;
  localparam int LAT    = 2;
  localparam int BUDGET = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arready, arvalid, rready, rvalid, rlast;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  axi_sram_slave #(.BASE_ADDR(32'h8000_0000), .MEM_WORDS(4096), .RD_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst), .io_slave_wready(wready), .io_slave_wvalid(wvalid),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
    .io_slave_bid(bid), .io_slave_arready(arready), .io_slave_arvalid(arvalid),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst), .io_slave_rready(rready),
    .io_slave_rvalid(rvalid), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] id, input logic [1:0] exp_resp);
    int n;
    @(negedge clock);
    awvalid = 1'b1; awaddr = a; awid = id;
    n = 0;
    while (!awready && n < BUDGET) begin @(negedge clock); n++; end
    chk("aw_wait", 32'(n < BUDGET), 32'd1);
    @(negedge clock);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = 1'b1;
    chk("wready", 32'(wready), 32'd1);
    @(negedge clock);
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("bid", 32'(bid), 32'(id));
    @(negedge clock);
    chk("bvalid_drop", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp, input int stall);
    int n;
    int lat;
    @(negedge clock);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; rready = 1'b0;
    n = 0;
    while (!arready && n < BUDGET) begin @(negedge clock); n++; end
    chk("ar_wait", 32'(n < BUDGET), 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < BUDGET) begin @(negedge clock); lat++; end
    chk("rd_latency", 32'(lat), 32'(LAT + 1));
    chk("rdata", rdata, exp_data);
    chk("rresp", 32'(rresp), 32'(exp_resp));
    chk("rlast", 32'(rlast), 32'd1);
    chk("rid", 32'(rid), 32'(id));
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_rdata", rdata, exp_data);
      chk("stall_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
    arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_arready", 32'(arready), 32'd1);

    // Single write, then read back with a 3-cycle rready stall
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'd5, 2'b00);
    do_read(32'h8000_0010, 4'd3, 8'd0, 32'hDEAD_BEEF, 2'b00, 3);

    // Byte strobes merge into the existing word; addr[1:0] ignored on read
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 4'd7, 2'b00);
    do_read(32'h8000_0013, 4'd1, 8'd0, 32'hDE22_BE44, 2'b00, 0);

    // Out of range: below base, and one word past the top must not alias word 0
    do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 4'd2, 2'b00);
    do_read(32'h7FFF_FFFC, 4'd4, 8'd0, 32'd0, 2'b10, 0);
    do_write(32'h8000_4000, 32'hCAFE_F00D, 4'hF, 4'd6, 2'b10);
    do_read(32'h8000_0000, 4'd8, 8'd0, 32'h0BAD_F00D, 2'b00, 0);

    // Last word of memory is in range
    do_write(32'h8000_3FFC, 32'h5A5A_A5A5, 4'hF, 4'hF, 2'b00);
    do_read(32'h8000_3FFC, 4'hE, 8'd0, 32'h5A5A_A5A5, 2'b00, 1);

    // Reset during R_WAIT abandons the read
    @(negedge clock);
    arvalid = 1'b1; araddr = 32'h8000_0010; arid = 4'd2; arlen = 8'd0;
    @(negedge clock);
    arvalid = 1'b0;
    reset = 1'b1;
    chk("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge clock);
    chk("mid_rst_arready2", 32'(arready), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    end
    do_read(32'h8000_0010, 4'd9, 8'd0, 32'hDE22_BE44, 2'b00, 0);

`ifdef AXI_SLAVE_BURST_EN
    // Four-beat INCR read of words 1..4, back-to-back
    for (int i = 0; i < 4; i++)
      do_write(32'h8000_0000 + 32'(4 * i), 32'(i + 1), 4'hF, 4'd1, 2'b00);
    begin
      int n;
      @(negedge clock);
      arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd9; arlen = 8'd3; rready = 1'b1;
      @(negedge clock);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < BUDGET) begin @(negedge clock); n++; end
      chk("burst_wait", 32'(n < BUDGET), 32'd1);
      for (int i = 0; i < 4; i++) begin
        chk("burst_rvalid", 32'(rvalid), 32'd1);
        chk("burst_rdata", rdata, 32'(i + 1));
        chk("burst_rlast", 32'(rlast), 32'(i == 3));
        chk("burst_rid", 32'(rid), 32'd9);
        @(negedge clock);
      end
      rready = 1'b0;
      chk("burst_end", 32'(rvalid), 32'd0);
    end
`else
    // arlen is ignored: a single beat with rlast
    do_read(32'h8000_0010, 4'd6, 8'd3, 32'hDE22_BE44, 2'b00, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave) that terminates the core's AXI master port and backs it with an internal word-addressed SRAM model.
- Used as the memory target for simulation and FPGA bring-up of the AXI fetch/load/store path.
- Independent read and write channel FSMs.
- Programmable read latency.
- SLVERR on out-of-range addresses.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of memory word 0.
- MEM_WORDS, 4096, depth of SRAM in 32-bit words; must be a power of two.
- RD_LATENCY, 2, number of idle cycles inserted between AR handshake and first rvalid; 0..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_slave_awready  out  1  write address ready
- io_slave_awvalid  in  1  write address valid
- io_slave_awaddr  in  32  write byte address
- io_slave_awid  in  4  write transaction id
- io_slave_awlen  in  8  write beats minus one
- io_slave_awsize  in  3  write beat size (recorded, not checked)
- io_slave_awburst  in  2  burst type (INCR assumed)
- io_slave_wready  out  1  write data ready
- io_slave_wvalid  in  1  write data valid
- io_slave_wdata  in  32  write data
- io_slave_wstrb  in  4  byte enables
- io_slave_wlast  in  1  last write beat
- io_slave_bready  in  1  response ready
- io_slave_bvalid  out  1  response valid
- io_slave_bresp  out  2  OKAY=2'b00, SLVERR=2'b10
- io_slave_bid  out  4  echoed awid
- io_slave_arready  out  1  read address ready
- io_slave_arvalid  in  1  read address valid
- io_slave_araddr  in  32  read byte address
- io_slave_arid  in  4  read id
- io_slave_arlen  in  8  read beats minus one
- io_slave_arsize  in  3  read size (recorded, not checked)
- io_slave_arburst  in  2  burst type (INCR assumed)
- io_slave_rready  in  1  read data ready
- io_slave_rvalid  out  1  read data valid
- io_slave_rresp  out  2  OKAY/SLVERR
- io_slave_rdata  out  32  read data
- io_slave_rlast  out  1  last read beat
- io_slave_rid  out  4  echoed arid

Behaviour:
- Reset (clock and reset as decided: one clock; reset is synchronous and active-high):
  - While reset is high: all ready/valid outputs 0; bresp, rresp, rdata, bid, rid all 0; both FSMs to IDLE.
  - SRAM contents are not cleared.
  - Reset mid-transaction abandons it with no response.
- Address decode: word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
  - In range iff (addr - BASE_ADDR) < MEM_WORDS*4 (unsigned 32-bit compare).
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch addr, id and len (len forced to 0 without the burst feature); go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes whose wstrb bit is set into mem[word] (only if in range), then advances the address by 4. Beat count increments.
  - W_DATA exit: after beat len+1 is accepted, go to W_RESP. wlast is not used to terminate.
  - W_RESP: bvalid=1, bid=latched id. bresp=SLVERR if any beat was out of range, else OKAY. Outputs held stable until bready; then W_IDLE.
  - awready is never 1 outside W_IDLE, so only one outstanding write exists.
- Read FSM R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: arready=1. On handshake, latch addr, id, len; counter=RD_LATENCY; go to R_WAIT.
  - R_WAIT: decrement the counter each cycle. When it reaches 0, register rdata=mem[word] (0 if out of range) and rresp, and go to R_DATA. First rvalid therefore appears RD_LATENCY+1 cycles after the AR handshake edge.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). rdata, rresp and rlast are held stable while rvalid&!rready.
  - R_DATA on handshake: if last, go to R_IDLE. Otherwise, address+4 and the next beat's data is loaded the same edge, so beats are back-to-back with no re-wait.
- Read/write collision: a read samples memory at the edge entering R_DATA (or advancing a beat), so it sees every write committed at earlier edges. A same-edge write is not visible.
- Channels are fully independent; AR and AW may handshake in the same cycle.
- Address wrap: a burst crossing the top of memory goes out of range and gets SLVERR for those beats. There is no wrap into word 0.

Optional Feature:
- Macro AXI_SLAVE_BURST_EN.
- Defined: awlen/arlen honoured (1..256 beats INCR); rlast asserted on the final beat only.
- Undefined: awlen/arlen treated as 0; every transaction is single-beat; rlast=1 whenever rvalid=1; wlast ignored.

Test Plan:
- Single write: awaddr=0x8000_0010, wdata=0xDEAD_BEEF, wstrb=4'hF, bready=1 -> bvalid one cycle after the W beat, bresp=00, bid=awid. Then a read of 0x8000_0010 -> rdata=0xDEAD_BEEF, rresp=00, rlast=1.
- Byte strobe: write 0x1122_3344 with strb=4'b0101 over 0xDEAD_BEEF -> read returns 0xDE22_BE44.
- Latency: RD_LATENCY=2, AR handshake at cycle 10 -> rvalid first high cycle 13. Hold rready=0 for 3 cycles -> rdata unchanged, arready stays 0.
- Out of range: read 0x7FFF_FFFC and write 0x8000_4000 (MEM_WORDS=4096) -> rresp=10, rdata=0; bresp=10; memory unchanged.
- Burst (AXI_SLAVE_BURST_EN): arlen=3 at 0x8000_0000 after writing words 1,2,3,4 -> four back-to-back beats 1,2,3,4; rlast only on beat 4; rid echoed.
- Reset mid-read: assert reset during R_WAIT -> rvalid never rises, arready=0 during reset, arready=1 the cycle after reset deasserts.
